// File: rtl/jailbreak_audio_pkg.sv
// Shared types and helpers for the Jailbreak audio back-end.
// Sample type, full-scale limits and the saturating two-input add used by the mixer.
package jailbreak_audio_pkg;

  localparam int SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  localparam sample_t SAMPLE_MAX = 16'sh7FFF;
  localparam sample_t SAMPLE_MIN = 16'sh8000;

  // One guard bit is enough: disagreement between the top two bits means the sum left range.
  function automatic sample_t sat_add(input sample_t a, input sample_t b);
    logic signed [SAMPLE_W:0] s;
    s = $signed({a[SAMPLE_W-1], a}) + $signed({b[SAMPLE_W-1], b});
    if (s[SAMPLE_W] != s[SAMPLE_W-1])
      return s[SAMPLE_W] ? SAMPLE_MIN : SAMPLE_MAX;
    return s[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/jailbreak_audio_fifo.sv
// Small synchronous show-ahead FIFO; a push into a full FIFO is dropped.
// The head word is held in a register so it keeps its last value once the FIFO drains.
module jailbreak_audio_fifo #(
  parameter int DATA_W = 16,
  parameter int AW     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic signed [DATA_W-1:0] din,
  input  logic                     pop,
  output logic signed [DATA_W-1:0] dout,
  output logic                     full,
  output logic                     empty,
  output logic [AW:0]              level
);

  localparam logic [AW:0] DEPTH = (AW+1)'(1 << AW);
  localparam logic [AW:0] ONE   = (AW+1)'(1);

  logic signed [DATA_W-1:0] mem [1 << AW];
  logic [AW-1:0] rd_ptr, wr_ptr, rd_nxt;
  logic          push_ok, pop_ok;

  // Full is judged before any same-cycle pop, so a pop never rescues a push into a full FIFO.
  assign full    = (level == DEPTH);
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_nxt  = rd_ptr + AW'(1);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
      dout   <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_nxt;
      level <= level + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
      // With one entry left, the next head is the word being written this cycle.
      if (empty && push_ok) begin
        dout <= din;
      end else if (pop_ok) begin
        if (level > ONE)  dout <= mem[rd_nxt];
        else if (push_ok) dout <= din;
      end
    end
  end

endmodule

// File: rtl/jailbreak_audio_decim.sv
// Jailbreak audio back-end: mixes PSG and speech, box-car decimates 384 kHz to 48 kHz,
// and queues the results for the platform sink behind a valid/ready FIFO.
module jailbreak_audio_decim
  import jailbreak_audio_pkg::*;
#(
  parameter int W          = 16,
  parameter int DECIM_LOG2 = 3,
  parameter int FIFO_AW    = 2
) (
  input  logic                clk_49m,
  input  logic                reset,
  input  logic                in_cen,
  input  logic signed [W-1:0] psg_in,
  input  logic signed [W-1:0] speech_in,
  input  logic                mute,
  output logic signed [W-1:0] out_sample,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                overflow,
  output logic [FIFO_AW:0]    level
);

  localparam int ACC_W = W + DECIM_LOG2;

  // Arithmetic shift gives floor division, so -1/8 lands on -1 rather than 0.
  function automatic logic signed [W-1:0] window_avg(input logic signed [ACC_W-1:0] sum);
    logic signed [ACC_W-1:0] q;
    q = sum >>> DECIM_LOG2;
    return q[W-1:0];
  endfunction

  logic signed [W-1:0]     m_p0;
  logic signed [ACC_W-1:0] acc_p0, acc_sum_p0;
  logic [DECIM_LOG2-1:0]   cnt_p0;
  logic                    last_p0;

  logic                    push_p1;
  logic signed [W-1:0]     push_data_p1;

  logic                    fifo_full, fifo_empty;

  // Stage p0: mix, saturate and accumulate one window.
  assign m_p0       = mute ? '0 : sat_add(psg_in, speech_in);
  assign acc_sum_p0 = acc_p0 + $signed({{DECIM_LOG2{m_p0[W-1]}}, m_p0});
  assign last_p0    = &cnt_p0;

  always_ff @(posedge clk_49m) begin
    if (reset) begin
      acc_p0  <= '0;
      cnt_p0  <= '0;
      push_p1 <= 1'b0;
    end else begin
      push_p1 <= in_cen && last_p0;
      if (in_cen) begin
        cnt_p0 <= cnt_p0 + DECIM_LOG2'(1);
        acc_p0 <= last_p0 ? '0 : acc_sum_p0;
      end
    end
  end

  // Stage p1: window result registered for the FIFO push.
  always_ff @(posedge clk_49m) begin
    if (in_cen && last_p0) push_data_p1 <= window_avg(acc_sum_p0);
  end

  always_ff @(posedge clk_49m) begin
    if (reset)                      overflow <= 1'b0;
    else if (push_p1 && fifo_full)  overflow <= 1'b1;
  end

  jailbreak_audio_fifo #(
    .DATA_W (W),
    .AW     (FIFO_AW)
  ) u_fifo (
    .clk   (clk_49m),
    .rst   (reset),
    .push  (push_p1),
    .din   (push_data_p1),
    .pop   (out_ready),
    .dout  (out_sample),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign out_valid = !fifo_empty;

endmodule

// File: doc/jailbreak_audio_decim.md
Name: jailbreak_audio_decim

Overview:
Audio back-end stage directly downstream of the Jailbreak sound section. It takes the filtered SN76489 and VLM5030 streams at the DC-removal rate (~384 kHz), mixes and saturates them, and box-car decimates to 48 kHz. Results are buffered in a small show-ahead FIFO with a valid/ready handshake to the platform audio sink. It replaces the direct combinational sum at the sound output, so the framework receives clean, rate-matched samples.

Parameters:
W, 16, sample width of inputs and output (signed)
DECIM_LOG2, 3, log2 of input samples averaged per output sample (8 × 384 kHz → 48 kHz)
FIFO_AW, 2, FIFO address width (depth = 2^FIFO_AW = 4)

Ports:
clk_49m  in  1  system clock, 49.152 MHz
reset  in  1  synchronous, active-high reset
in_cen  in  1  input sample strobe, one clk_49m cycle wide (dcrm_cen rate)
psg_in  in  W  signed SN76489 path sample, post-LPF and gain
speech_in  in  W  signed VLM5030 path sample, post-inversion and gain
mute  in  1  forces the mixed input to 0 (pause)
out_sample  out  W  signed decimated sample at FIFO head
out_valid  out  1  FIFO non-empty
out_ready  in  1  sink accepts out_sample this cycle when out_valid=1
overflow  out  1  sticky: a window result was dropped because FIFO full
level  out  FIFO_AW+1  current FIFO occupancy

Behaviour:
- Interface: one clock (clk_49m). Reset is synchronous and active-high (port reset). Everything is in the clk_49m domain.
- Reset values: out_valid=0, out_sample=0, overflow=0, level=0, accumulator=0, window counter=0, FIFO pointers=0.
- Mix (combinational): m = mute ? 0 : psg_in + speech_in, computed at W+1 bits. Saturate to [-2^(W-1), 2^(W-1)-1].
- Accumulate: on in_cen, acc += sat(m); acc is W+DECIM_LOG2 bits signed and cannot overflow. Window counter (DECIM_LOG2 bits) increments on each in_cen and wraps.
- Window close: on the in_cen where counter == 2^DECIM_LOG2-1:
  - result = (acc + m_sat) >>> DECIM_LOG2 (arithmetic shift, floor).
  - acc reloads to 0 and counter wraps to 0 in the same cycle.
  - Push request is registered and occurs the next cycle (push at t+1).
- FIFO push: when a push is requested and level == depth, data is dropped, overflow←1, and pointers are unchanged. A simultaneous pop in that cycle does NOT rescue the push (full is evaluated before pop); the drop still occurs.
- FIFO pop: when out_valid & out_ready, the read pointer advances.
- Push on an empty FIFO: out_valid rises the cycle after the push (t+2 from the closing in_cen). out_sample is presented registered, show-ahead.
- Simultaneous push and pop when 0 < level < depth: level is unchanged and the order is preserved.
- out_sample holds its last value when out_valid=0; it is not zeroed.
- in_cen while reset=1: ignored.
- Reset mid-window: the partial accumulation is discarded and no sample is pushed.
- overflow is cleared only by reset.
- mute does not flush the FIFO or the accumulator. Muted cycles contribute 0, so fading into mute is averaged across at most one window.

Decomposition:
- Shared package jailbreak_audio_pkg holds:
  - typedef sample_t (logic signed [W-1:0])
  - constants SAMPLE_MAX = 16'sh7FFF and SAMPLE_MIN = 16'sh8000
  - function sat_add(sample_t, sample_t) returning sample_t
- One sub-module, jailbreak_audio_fifo: a parameterized synchronous show-ahead FIFO with push, pop, full, empty, level and a drop-on-full policy.
- Mixer, accumulator and window control stay in the top block.

Test Plan:
- Constant average: psg_in=1000, speech_in=200, 8 in_cen pulses 128 cycles apart, out_ready=1 → one sample 1200, out_valid high exactly 1 cycle, and it rises 2 cycles after the 8th in_cen.
- Positive saturation: psg_in=30000, speech_in=10000 for a full window → 32767. Negative saturation: psg_in=-32768, speech_in=-1 → -32768.
- Floor rounding: seven strobes at 0 and one at -1 → -1 (floor of -1/8). Seven at 0 and one at +7 → 0.
- Backpressure/overflow: out_ready=0, windows with constant values 1, 2, 3, 4, 5 → level=4, overflow=1. Then out_ready=1 → pops 1, 2, 3, 4 in order, then out_valid=0. overflow stays 1.
- Mute: psg_in=5000, mute=1 for 4 strobes then 0 for 4 strobes → 2500. A full muted window → 0.
- Reset mid-window: 5 strobes at 8000, assert reset 1 cycle, then 8 strobes at 100 → exactly one sample, 100, and level=0 after pop.
